// File: rtl/vga_color_dither.sv
// VGA output stage: two-cycle registered colour reduction with sync/DE alignment.
// Define VGA_DITHER_EN to enable 4x4 ordered (Bayer) dithering; otherwise plain truncation.
module vga_color_dither #(
    parameter int unsigned IN_W          = 8,
    parameter int unsigned OUT_W         = 4,
    parameter bit          HS_ACTIVE_LOW = 1'b1,
    parameter bit          VS_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK_25MHZ,
    input  logic             RESET_N,
    input  logic             IN_HSYNC,
    input  logic             IN_VSYNC,
    input  logic             IN_DE,
    input  logic [IN_W-1:0]  IN_RED,
    input  logic [IN_W-1:0]  IN_GREEN,
    input  logic [IN_W-1:0]  IN_BLUE,
    output logic             VGA_HSYNC,
    output logic             VGA_VSYNC,
    output logic [OUT_W-1:0] VGA_RED,
    output logic [OUT_W-1:0] VGA_GREEN,
    output logic [OUT_W-1:0] VGA_BLUE
);

    localparam int unsigned D       = (OUT_W <= IN_W) ? IN_W - OUT_W : 0;
    localparam logic        HS_IDLE = HS_ACTIVE_LOW;
    localparam logic        VS_IDLE = VS_ACTIVE_LOW;

    if (OUT_W > IN_W) begin : g_bad_width
        $error("vga_color_dither: OUT_W must not exceed IN_W");
    end

    logic            hs_q, vs_q, de_q;
    logic [IN_W-1:0] red_q, green_q, blue_q;

    // Stage-1 syncs reset to idle so no active pulse escapes just after release.
    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            hs_q    <= HS_IDLE;
            vs_q    <= VS_IDLE;
            de_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hs_q    <= IN_HSYNC;
            vs_q    <= IN_VSYNC;
            de_q    <= IN_DE;
            red_q   <= IN_RED;
            green_q <= IN_GREEN;
            blue_q  <= IN_BLUE;
        end
    end

`ifdef VGA_DITHER_EN
    localparam int unsigned SHL = (D >= 4) ? D - 4 : 0;
    localparam int unsigned SHR = (D >= 4) ? 0 : 4 - D;

    // col_q/row_q hold the Bayer phase of the pixel currently in stage 1.
    logic [1:0]  col_q, row_q;
    logic [3:0]  bayer;
    logic [IN_W:0] thr;
    logic        vs_active;

    assign vs_active = IN_VSYNC ^ VS_ACTIVE_LOW;

    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            col_q <= 2'd0;
            row_q <= 2'd0;
        end else begin
            col_q <= (IN_DE && de_q) ? col_q + 2'd1 : 2'd0;
            if (vs_active) begin
                row_q <= 2'd0;
            end else if (de_q && !IN_DE) begin
                row_q <= row_q + 2'd1;
            end
        end
    end

    always_comb begin
        bayer = 4'd0;
        case ({row_q, col_q})
            4'h0: bayer = 4'd0;
            4'h1: bayer = 4'd8;
            4'h2: bayer = 4'd2;
            4'h3: bayer = 4'd10;
            4'h4: bayer = 4'd12;
            4'h5: bayer = 4'd4;
            4'h6: bayer = 4'd14;
            4'h7: bayer = 4'd6;
            4'h8: bayer = 4'd3;
            4'h9: bayer = 4'd11;
            4'hA: bayer = 4'd1;
            4'hB: bayer = 4'd9;
            4'hC: bayer = 4'd15;
            4'hD: bayer = 4'd7;
            4'hE: bayer = 4'd13;
            4'hF: bayer = 4'd5;
            default: bayer = 4'd0;
        endcase
    end

    assign thr = ((IN_W+1)'(bayer) << SHL) >> SHR;

    function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] c);
        logic [IN_W:0] sum;
        sum = {1'b0, c} + thr;
        if (sum[IN_W]) begin
            return '1;
        end
        return sum[IN_W-1:D];
    endfunction
`else
    function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] c);
        return c[IN_W-1:D];
    endfunction
`endif

    logic [OUT_W-1:0] red_d, green_d, blue_d;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (de_q) begin
            red_d   = reduce(red_q);
            green_d = reduce(green_q);
            blue_d  = reduce(blue_q);
        end
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            VGA_HSYNC <= HS_IDLE;
            VGA_VSYNC <= VS_IDLE;
            VGA_RED   <= '0;
            VGA_GREEN <= '0;
            VGA_BLUE  <= '0;
        end else begin
            VGA_HSYNC <= hs_q;
            VGA_VSYNC <= vs_q;
            VGA_RED   <= red_d;
            VGA_GREEN <= green_d;
            VGA_BLUE  <= blue_d;
        end
    end

endmodule

// File: tb/tb_vga_color_dither.sv
// Directed bench for vga_color_dither (IN_W=8, OUT_W=4, active-low syncs).
// Expectations follow VGA_DITHER_EN when defined, plain truncation otherwise.
module tb_vga_color_dither;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_hs, in_vs, in_de;
    logic [7:0] in_r, in_g, in_b;
    logic       vga_hs, vga_vs;
    logic [3:0] vga_r, vga_g, vga_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_color_dither #(
        .IN_W          (8),
        .OUT_W         (4),
        .HS_ACTIVE_LOW (1'b1),
        .VS_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK_25MHZ (clk),
        .RESET_N   (rst_n),
        .IN_HSYNC  (in_hs),
        .IN_VSYNC  (in_vs),
        .IN_DE     (in_de),
        .IN_RED    (in_r),
        .IN_GREEN  (in_g),
        .IN_BLUE   (in_b),
        .VGA_HSYNC (vga_hs),
        .VGA_VSYNC (vga_vs),
        .VGA_RED   (vga_r),
        .VGA_GREEN (vga_g),
        .VGA_BLUE  (vga_b)
    );

    typedef struct {
        logic       de, hs, vs;
        logic [7:0] r, g, b;
        logic [3:0] er, eg, eb;  // dithered expectation
        logic [3:0] tr, tg, tb;  // truncated expectation
    } vec_t;

    vec_t vecs[$];

`ifdef VGA_DITHER_EN
    localparam logic [3:0] RST_C3 = 4'd9;
`else
    localparam logic [3:0] RST_C3 = 4'd8;
`endif

    task automatic add(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb,
                       input logic [3:0] tr, input logic [3:0] tg, input logic [3:0] tb);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs;
        v.r = r; v.g = g; v.b = b;
        v.er = er; v.eg = eg; v.eb = eb;
        v.tr = tr; v.tg = tg; v.tb = tb;
        vecs.push_back(v);
    endtask

    // Active pixel, same colour on all channels.
    task automatic pix(input logic [7:0] c, input logic [3:0] e, input logic [3:0] t);
        add(1'b1, 1'b1, 1'b1, c, c, c, e, e, e, t, t, t);
    endtask

    // Blanked cycle with bright colour that must not reach the pins.
    task automatic blank(input logic hs, input logic vs);
        add(1'b0, hs, vs, 8'hFF, 8'hFF, 8'hFF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_de = de; in_hs = hs; in_vs = vs;
        in_r = r; in_g = g; in_b = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [13:0] want);
        logic [13:0] got;
        got = {vga_hs, vga_vs, vga_r, vga_g, vga_b};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got hs=%b vs=%b rgb=%h%h%h, want hs=%b vs=%b rgb=%h%h%h",
                     name, got[13], got[12], got[11:8], got[7:4], got[3:0],
                     want[13], want[12], want[11:8], want[7:4], want[3:0]);
        end
    endtask

    initial begin
        logic [13:0] want;

        // vsync pulse, then blanking
        blank(1'b1, 1'b0);
        blank(1'b1, 1'b1);
        // line 0 (row 0): r=87, g=00, b=FF
        add(1, 1, 1, 8'h87, 8'h00, 8'hFF, 4'h8, 4'h0, 4'hF, 4'h8, 4'h0, 4'hF);
        add(1, 1, 1, 8'h87, 8'h00, 8'hFF, 4'h8, 4'h0, 4'hF, 4'h8, 4'h0, 4'hF);
        add(1, 1, 1, 8'h87, 8'h00, 8'hFF, 4'h8, 4'h0, 4'hF, 4'h8, 4'h0, 4'hF);
        add(1, 1, 1, 8'h87, 8'h00, 8'hFF, 4'h9, 4'h0, 4'hF, 4'h8, 4'h0, 4'hF);
        pix(8'h87, 4'h8, 4'h8); pix(8'h87, 4'h8, 4'h8);
        pix(8'h87, 4'h8, 4'h8); pix(8'h87, 4'h9, 4'h8);
        blank(1'b0, 1'b1);
        blank(1'b1, 1'b1);
        // line 1 (row 1): t=12,4,14,6
        pix(8'h87, 4'h9, 4'h8); pix(8'h87, 4'h8, 4'h8);
        pix(8'h87, 4'h9, 4'h8); pix(8'h87, 4'h8, 4'h8);
        blank(1'b1, 1'b1);
        // line 2 (row 2): t=3,11,1,9
        pix(8'h87, 4'h8, 4'h8); pix(8'h87, 4'h9, 4'h8);
        pix(8'h87, 4'h8, 4'h8); pix(8'h87, 4'h9, 4'h8);
        blank(1'b1, 1'b1);
        // line 3 (row 3): t=15,7,13,5 incl. saturation
        pix(8'hFF, 4'hF, 4'hF); pix(8'hFF, 4'hF, 4'hF);
        pix(8'h10, 4'h1, 4'h1); pix(8'h7B, 4'h8, 4'h7);
        blank(1'b1, 1'b1);
        // line 4 wraps to row 0
        pix(8'h87, 4'h8, 4'h8); pix(8'h7E, 4'h8, 4'h7);
        blank(1'b1, 1'b1);
        // line 5 (row 1), then vsync coincident with DE fall
        pix(8'h87, 4'h9, 4'h8);
        blank(1'b1, 1'b0);
        blank(1'b1, 1'b1);
        // line 6 must be row 0
        pix(8'h87, 4'h8, 4'h8); pix(8'h87, 4'h8, 4'h8);
        blank(1'b1, 1'b1);

        // reset holds outputs idle even with active inputs
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        step();
        step();
        chk("reset_state", {1'b1, 1'b1, 12'h000});

        rst_n = 1'b1;
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) begin
                drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
            end else begin
                drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
            end
            step();
            if (i >= 1) begin
`ifdef VGA_DITHER_EN
                want = {vecs[i-1].hs, vecs[i-1].vs, vecs[i-1].er, vecs[i-1].eg, vecs[i-1].eb};
`else
                want = {vecs[i-1].hs, vecs[i-1].vs, vecs[i-1].tr, vecs[i-1].tg, vecs[i-1].tb};
`endif
                chk($sformatf("vec%0d", i - 1), want);
            end
        end

        // mid-line reset: row counter is nonzero beforehand
        drive(1'b1, 1'b0, 1'b1, 8'h87, 8'h87, 8'h87);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("reset_midline", {1'b1, 1'b1, 12'h000});
        rst_n = 1'b1;
        step();
        chk("release_first", {1'b1, 1'b1, 12'h000});
        step();
        chk("resume_col0", {1'b0, 1'b1, 12'h888});
        step();
        step();
        step();
        chk("resume_col3", {1'b0, 1'b1, RST_C3, RST_C3, RST_C3});

        // sync latency: two edges from input change to pin change
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        step();
        step();
        step();
        in_hs = 1'b0;
        step();
        chk("hs_lat_edge1", {1'b1, 1'b1, 12'h000});
        step();
        chk("hs_lat_edge2", {1'b0, 1'b1, 12'h000});
        in_vs = 1'b0;
        step();
        chk("vs_lat_edge1", {1'b0, 1'b1, 12'h000});
        step();
        chk("vs_lat_edge2", {1'b0, 1'b0, 12'h000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
